vend_transaction_controller: RTL and testbench
==============================================

Name: vend_transaction_controller

Overview:
- Sequences one vending purchase: coin accumulation, item select, stock/price check, dispense handshake, change return.
- Owns the credit register and per-item stock counters.
- Drives the moneyIn/price/buy/change/stock inputs of the seven-segment display controller.
- Sits between the coin/keypad front end and the dispenser motor interface.

Parameters:
- NUM_ITEMS, 5, number of selectable items; width of one-hot select.
- MONEY_W, 12, credit/change width (pence).
- PRICE_W, 8, price width (pence).
- STOCK_W, 3, per-item stock counter width.
- INIT_STOCK, 4, stock loaded into every item at reset.
- TIMEOUT_CYCLES, 50_000_000, idle cycles in CREDIT before auto-refund (1 s at 50 MHz).

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  one-cycle pulse, coin accepted by front end
- coin_value  in  8  value of coin in pence, sampled with coin_valid
- select  in  NUM_ITEMS  one-hot item selection, level
- price_table  in  NUM_ITEMS*PRICE_W  packed prices; item i at [i*PRICE_W +: PRICE_W]
- buy  in  1  one-cycle purchase request
- cancel  in  1  one-cycle refund request
- restock  in  1  one-cycle pulse: reload all stock to INIT_STOCK (IDLE/CREDIT only)
- dispense_ack  in  1  dispenser done
- dispense_valid  out  1  dispense request, held until ack
- dispense_item  out  NUM_ITEMS  one-hot item being dispensed
- moneyIn  out  MONEY_W  current credit
- price  out  PRICE_W  price of selected item; 0 if select not one-hot
- stock  out  1  selected item has stock > 0
- buy_o  out  1  one-cycle pulse to display controller on every evaluated buy
- change  out  MONEY_W  change/refund amount, valid with change_valid
- change_valid  out  1  one-cycle pulse
- fault  out  2  registered last result: 0 none, 1 no selection, 2 insufficient, 3 out of stock
- busy  out  1  high in CHECK, DISPENSE, CHANGE

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - moneyIn, change, change_valid, dispense_valid, dispense_item, buy_o, fault all 0.
  - All stock counters set to INIT_STOCK.
- States: IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
- IDLE:
  - coin_valid: credit = coin_value; go to CREDIT.
  - buy: buy_o pulse, fault=1, stay in IDLE.
  - cancel: ignored.
- CREDIT:
  - coin_valid: credit += coin_value.
    - If the sum exceeds 4095, the coin is not added and credit is unchanged; refund of the coin is the front end's concern.
  - buy: latch select and price; go to CHECK next cycle.
  - cancel: change=credit; go to CHANGE.
  - Timeout: counter clears on coin/buy; on reaching TIMEOUT_CYCLES-1, behaves as cancel.
  - Simultaneous events, priority: cancel > buy > coin. A coin lost to priority is dropped.
- CHECK (1 cycle):
  - buy_o pulses this cycle.
  - Latched select not one-hot: fault=1; back to CREDIT.
  - Stock 0: fault=3; back to CREDIT, credit kept.
  - credit < price: fault=2; back to CREDIT.
  - Otherwise: fault=0; decrement that item's stock; go to DISPENSE.
- DISPENSE:
  - dispense_valid=1 and dispense_item stable until the cycle dispense_ack is sampled high.
  - Then change = credit - price, credit=0, go to CHANGE.
  - coin, buy and cancel are ignored.
- CHANGE:
  - change_valid=1 for exactly one cycle; credit=0; go to IDLE.
  - change holds its value until the next change_valid.
- Zero change (exact payment): change_valid still pulses with change=0.
- Stock counters never wrap below 0; restock outside IDLE/CREDIT is ignored.
- Reset mid-DISPENSE: dispense_valid drops immediately; credit is lost; stock is reloaded.
- Latencies:
  - buy in CREDIT to dispense_valid: 2 cycles.
  - dispense_ack to change_valid: 1 cycle.

Optional Feature:
- Macro: VEND_AUDIT_EN.
- Defined:
  - Adds outputs sales_count (16 bit) and revenue (24 bit).
  - On each DISPENSE exit, they increment by 1 and by price, saturating at all-ones.
  - Reset clears both.
- Undefined: ports and logic absent; behaviour is otherwise identical.

Decomposition:
- vend_pkg:
  - state enum.
  - Fault code constants NO_FAULT, NO_SEL, INSUFFICIENT, OUT_OF_STOCK.
  - MONEY_MAX=4095.
  - Default widths.
- Sub-module stock_bank:
  - NUM_ITEMS counters with one-hot decrement, restock and a zero-flag read for the selected item.
  - Holds the only per-item storage.

Test Plan:
- coins 50, 50; select=00001, price 100; buy → dispense_valid 2 cycles later; ack → change_valid with change=0; moneyIn=0; stock(item0)=3.
- coin 200; select=00010, price 150; buy; ack → change=50, fault=0.
- coin 60; select=00001, price 100; buy → fault=2, no dispense, moneyIn stays 60; cancel → change=60.
- Item 2 bought 4 times from INIT_STOCK=4; fifth buy with credit 100 → fault=3, stock=0, credit kept; restock → stock=1.
- buy with select=00011 or 00000 → fault=1, buy_o pulses, state unchanged.
- coin 80; buy; reset low during DISPENSE → dispense_valid=0 same cycle, moneyIn=0, all stock=4. Separately: coin 10 and TIMEOUT_CYCLES=16 → change_valid with change=10 after 16 idle cycles.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending transaction controller.
// States, fault codes and default widths used by the top and stock bank.
package vend_pkg;

  localparam int NUM_ITEMS_D  = 5;
  localparam int MONEY_W_D    = 12;
  localparam int PRICE_W_D    = 8;
  localparam int STOCK_W_D    = 3;
  localparam int INIT_STOCK_D = 4;
  localparam int TIMEOUT_D    = 50_000_000;

  localparam int MONEY_MAX = 4095;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  typedef logic [1:0] fault_t;

  localparam fault_t NO_FAULT     = 2'd0;
  localparam fault_t NO_SEL       = 2'd1;
  localparam fault_t INSUFFICIENT = 2'd2;
  localparam fault_t OUT_OF_STOCK = 2'd3;

endpackage

// File: rtl/vend_transaction_controller_stock_bank.sv
// Per-item stock counters: one-hot decrement, global restock,
// an availability read for the live selection and an empty read for checks.
module stock_bank
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = NUM_ITEMS_D,
  parameter int STOCK_W    = STOCK_W_D,
  parameter int INIT_STOCK = INIT_STOCK_D
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 restock,
  input  logic                 dec,
  input  logic [NUM_ITEMS-1:0] dec_sel,
  input  logic [NUM_ITEMS-1:0] rd_sel,
  output logic                 rd_avail,
  input  logic [NUM_ITEMS-1:0] chk_sel,
  output logic                 chk_zero
);

  logic [STOCK_W-1:0] cnt [NUM_ITEMS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        cnt[i] <= STOCK_W'(INIT_STOCK);
    end else if (restock) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        cnt[i] <= STOCK_W'(INIT_STOCK);
    end else if (dec) begin
      // empty counters hold at zero
      for (int i = 0; i < NUM_ITEMS; i++)
        if (dec_sel[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
    end
  end

  always_comb begin
    rd_avail = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (rd_sel[i] && cnt[i] != '0)
        rd_avail = 1'b1;
    if (!$onehot(rd_sel))
      rd_avail = 1'b0;
  end

  always_comb begin
    chk_zero = 1'b1;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (chk_sel[i])
        chk_zero = (cnt[i] == '0);
    if (!$onehot(chk_sel))
      chk_zero = 1'b1;
  end

endmodule

// File: rtl/vend_transaction_controller.sv
// One vending purchase: credit, select, check, dispense, change.
// Define VEND_AUDIT_EN to add sales_count / revenue audit counters.
module vend_transaction_controller
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS      = NUM_ITEMS_D,
  parameter int MONEY_W        = MONEY_W_D,
  parameter int PRICE_W        = PRICE_W_D,
  parameter int STOCK_W        = STOCK_W_D,
  parameter int INIT_STOCK     = INIT_STOCK_D,
  parameter int TIMEOUT_CYCLES = TIMEOUT_D
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         coin_valid,
  input  logic [7:0]                   coin_value,
  input  logic [NUM_ITEMS-1:0]         select,
  input  logic [NUM_ITEMS*PRICE_W-1:0] price_table,
  input  logic                         buy,
  input  logic                         cancel,
  input  logic                         restock,
  input  logic                         dispense_ack,
  output logic                         dispense_valid,
  output logic [NUM_ITEMS-1:0]         dispense_item,
  output logic [MONEY_W-1:0]           moneyIn,
  output logic [PRICE_W-1:0]           price,
  output logic                         stock,
  output logic                         buy_o,
  output logic [MONEY_W-1:0]           change,
  output logic                         change_valid,
  output logic [1:0]                   fault,
`ifdef VEND_AUDIT_EN
  output logic [15:0]                  sales_count,
  output logic [23:0]                  revenue,
`endif
  output logic                         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = MONEY_W + 1;

  state_t               state;
  logic [NUM_ITEMS-1:0] sel_q;
  logic [PRICE_W-1:0]   price_q;
  logic [PRICE_W-1:0]   sel_price;
  logic [TW-1:0]        tmo;
  logic [CW-1:0]        coin_sum;
  logic                 coin_ovf;
  logic                 tmo_hit;
  logic                 sel_ok;
  logic                 chk_zero;
  logic                 short_money;
  logic                 dec;
  logic                 restock_en;

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      if (select[i])
        sel_price = price_table[i*PRICE_W +: PRICE_W];
    if (!$onehot(select))
      sel_price = '0;
  end

  assign price       = sel_price;
  assign coin_sum    = {1'b0, moneyIn} + CW'(coin_value);
  assign coin_ovf    = coin_sum > CW'(MONEY_MAX);
  assign tmo_hit     = tmo == TW'(TIMEOUT_CYCLES - 1);
  assign sel_ok      = $onehot(sel_q);
  assign short_money = moneyIn < MONEY_W'(price_q);
  assign dec         = (state == S_CHECK) && sel_ok
                       && !chk_zero && !short_money;
  assign restock_en  = restock
                       && (state == S_IDLE || state == S_CREDIT);
  assign busy        = (state == S_CHECK) || (state == S_DISPENSE)
                       || (state == S_CHANGE);

  stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clock    (clock),
    .reset    (reset),
    .restock  (restock_en),
    .dec      (dec),
    .dec_sel  (sel_q),
    .rd_sel   (select),
    .rd_avail (stock),
    .chk_sel  (sel_q),
    .chk_zero (chk_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      moneyIn        <= '0;
      change         <= '0;
      change_valid   <= 1'b0;
      dispense_valid <= 1'b0;
      dispense_item  <= '0;
      buy_o          <= 1'b0;
      fault          <= NO_FAULT;
      sel_q          <= '0;
      price_q        <= '0;
      tmo            <= '0;
    end else begin
      buy_o        <= 1'b0;
      change_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (buy) begin
            buy_o <= 1'b1;
            fault <= NO_SEL;
          end else if (coin_valid) begin
            moneyIn <= MONEY_W'(coin_value);
            tmo     <= '0;
            state   <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel || tmo_hit) begin
            change       <= moneyIn;
            change_valid <= 1'b1;
            state        <= S_CHANGE;
          end else if (buy) begin
            sel_q   <= select;
            price_q <= sel_price;
            buy_o   <= 1'b1;
            tmo     <= '0;
            state   <= S_CHECK;
          end else if (coin_valid) begin
            // an overflowing coin is dropped, credit unchanged
            if (!coin_ovf)
              moneyIn <= coin_sum[MONEY_W-1:0];
            tmo <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_CHECK: begin
          tmo <= '0;
          if (!sel_ok) begin
            fault <= NO_SEL;
            state <= S_CREDIT;
          end else if (chk_zero) begin
            fault <= OUT_OF_STOCK;
            state <= S_CREDIT;
          end else if (short_money) begin
            fault <= INSUFFICIENT;
            state <= S_CREDIT;
          end else begin
            fault          <= NO_FAULT;
            dispense_valid <= 1'b1;
            dispense_item  <= sel_q;
            state          <= S_DISPENSE;
          end
        end
        S_DISPENSE: begin
          if (dispense_ack) begin
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change         <= moneyIn - MONEY_W'(price_q);
            change_valid   <= 1'b1;
            moneyIn        <= '0;
            state          <= S_CHANGE;
          end
        end
        S_CHANGE: begin
          moneyIn <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VEND_AUDIT_EN
  logic [24:0] rev_sum;

  assign rev_sum = {1'b0, revenue} + 25'(price_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sales_count <= '0;
      revenue     <= '0;
    end else if (state == S_DISPENSE && dispense_ack) begin
      if (!(&sales_count))
        sales_count <= sales_count + 1'b1;
      revenue <= rev_sum[24] ? '1 : rev_sum[23:0];
    end
  end
`endif

endmodule

// File: tb/tb_vend_transaction_controller.sv
// Directed-vector bench for vend_transaction_controller.
// Built with a short refund timeout so the auto-refund path is reachable.
module tb_vend_transaction_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        coin_valid = 1'b0;
  logic [7:0]  coin_value = '0;
  logic [4:0]  select = '0;
  logic [39:0] price_table;
  logic        buy = 1'b0;
  logic        cancel = 1'b0;
  logic        restock = 1'b0;
  logic        dispense_ack = 1'b0;
  logic        dispense_valid;
  logic [4:0]  dispense_item;
  logic [11:0] moneyIn;
  logic [7:0]  price;
  logic        stock;
  logic        buy_o;
  logic [11:0] change;
  logic        change_valid;
  logic [1:0]  fault;
  logic        busy;
`ifdef VEND_AUDIT_EN
  logic [15:0] sales_count;
  logic [23:0] revenue;
`endif

  int tests = 0;
  int fails = 0;

  // item prices: 0:100 1:150 2:25 3:80 4:200
  assign price_table = {8'd200, 8'd80, 8'd25, 8'd150, 8'd100};

  always #5 clock = ~clock;

  vend_transaction_controller #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .coin_valid     (coin_valid),
    .coin_value     (coin_value),
    .select         (select),
    .price_table    (price_table),
    .buy            (buy),
    .cancel         (cancel),
    .restock        (restock),
    .dispense_ack   (dispense_ack),
    .dispense_valid (dispense_valid),
    .dispense_item  (dispense_item),
    .moneyIn        (moneyIn),
    .price          (price),
    .stock          (stock),
    .buy_o          (buy_o),
    .change         (change),
    .change_valid   (change_valid),
    .fault          (fault),
`ifdef VEND_AUDIT_EN
    .sales_count    (sales_count),
    .revenue        (revenue),
`endif
    .busy           (busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_coin(input logic [7:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
  endtask

  task automatic press_buy();
    buy = 1'b1;
    tick();
    buy = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic press_restock();
    restock = 1'b1;
    tick();
    restock = 1'b0;
  endtask

  task automatic give_ack();
    dispense_ack = 1'b1;
    tick();
    dispense_ack = 1'b0;
  endtask

  task automatic purchase(input logic [7:0] v, input logic [4:0] s);
    put_coin(v);
    select = s;
    press_buy();
    tick();
    give_ack();
    tick();
  endtask

  task automatic test_reset();
    select = 5'b00100;
    repeat (3) tick();
    tests++;
    if (moneyIn !== 12'd0 || change !== 12'd0) begin
      fails++;
      $display("FAIL rst_money moneyIn=%0d change=%0d want 0 0", moneyIn, change);
    end
    tests++;
    if ({dispense_valid, change_valid, buy_o, busy} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_flags got %b want 0000",
               {dispense_valid, change_valid, buy_o, busy});
    end
    tests++;
    if (fault !== 2'd0 || dispense_item !== 5'd0) begin
      fails++;
      $display("FAIL rst_fault fault=%0d item=%b want 0 00000", fault, dispense_item);
    end
    tests++;
    if (stock !== 1'b1) begin
      fails++;
      $display("FAIL rst_stock got %b want 1", stock);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_exact_pay();
    put_coin(8'd50);
    put_coin(8'd50);
    select = 5'b00001;
    tests++;
    if (moneyIn !== 12'd100 || price !== 8'd100) begin
      fails++;
      $display("FAIL exact_credit moneyIn=%0d price=%0d want 100 100", moneyIn, price);
    end
    press_buy();
    tests++;
    if ({buy_o, busy, dispense_valid} !== 3'b110) begin
      fails++;
      $display("FAIL exact_check got %b want 110", {buy_o, busy, dispense_valid});
    end
    tick();
    tests++;
    if (dispense_valid !== 1'b1 || dispense_item !== 5'b00001) begin
      fails++;
      $display("FAIL exact_disp dv=%b item=%b want 1 00001", dispense_valid, dispense_item);
    end
    tick();
    tests++;
    if (dispense_valid !== 1'b1 || dispense_item !== 5'b00001) begin
      fails++;
      $display("FAIL exact_hold dv=%b item=%b want 1 00001", dispense_valid, dispense_item);
    end
    give_ack();
    tests++;
    if ({change_valid, dispense_valid} !== 2'b10 || change !== 12'd0 || moneyIn !== 12'd0) begin
      fails++;
      $display("FAIL exact_change cv=%b dv=%b change=%0d money=%0d want 1 0 0 0",
               change_valid, dispense_valid, change, moneyIn);
    end
    tick();
    tests++;
    if (change_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL exact_idle cv=%b busy=%b want 0 0", change_valid, busy);
    end
  endtask

  task automatic test_no_select();
    select = 5'b00011;
    tests++;
    if (price !== 8'd0) begin
      fails++;
      $display("FAIL nosel_price got %0d want 0", price);
    end
    press_buy();
    tests++;
    if ({buy_o, busy} !== 2'b10 || fault !== 2'd1 || moneyIn !== 12'd0) begin
      fails++;
      $display("FAIL nosel_idle buy_o=%b busy=%b fault=%0d money=%0d want 1 0 1 0",
               buy_o, busy, fault, moneyIn);
    end
    tick();
    put_coin(8'd30);
    select = 5'b00000;
    press_buy();
    tests++;
    if (buy_o !== 1'b1) begin
      fails++;
      $display("FAIL nosel_buyo got %b want 1", buy_o);
    end
    tick();
    tests++;
    if (fault !== 2'd1 || moneyIn !== 12'd30 || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL nosel_credit fault=%0d money=%0d dv=%b want 1 30 0",
               fault, moneyIn, dispense_valid);
    end
    press_cancel();
    tick();
  endtask

  task automatic test_change();
    put_coin(8'd200);
    select = 5'b00010;
    press_buy();
    tick();
    give_ack();
    tests++;
    if (change_valid !== 1'b1 || change !== 12'd50 || fault !== 2'd0) begin
      fails++;
      $display("FAIL change cv=%b change=%0d fault=%0d want 1 50 0",
               change_valid, change, fault);
    end
    tick();
    tests++;
    if (change !== 12'd50) begin
      fails++;
      $display("FAIL change_hold got %0d want 50", change);
    end
  endtask

  task automatic test_insufficient();
    put_coin(8'd60);
    select = 5'b00001;
    press_buy();
    tick();
    tests++;
    if (fault !== 2'd2 || moneyIn !== 12'd60 || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL insuf fault=%0d money=%0d dv=%b want 2 60 0",
               fault, moneyIn, dispense_valid);
    end
    press_cancel();
    tests++;
    if (change_valid !== 1'b1 || change !== 12'd60) begin
      fails++;
      $display("FAIL insuf_refund cv=%b change=%0d want 1 60", change_valid, change);
    end
    tick();
  endtask

  task automatic test_overflow();
    repeat (16) put_coin(8'd255);
    put_coin(8'd255);
    tests++;
    if (moneyIn !== 12'd4080) begin
      fails++;
      $display("FAIL ovf_drop got %0d want 4080", moneyIn);
    end
    put_coin(8'd15);
    tests++;
    if (moneyIn !== 12'd4095) begin
      fails++;
      $display("FAIL ovf_max got %0d want 4095", moneyIn);
    end
    // cancel outranks a simultaneous coin
    coin_valid = 1'b1;
    coin_value = 8'd5;
    cancel = 1'b1;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
    cancel = 1'b0;
    tests++;
    if (change_valid !== 1'b1 || change !== 12'd4095) begin
      fails++;
      $display("FAIL prio_cancel cv=%b change=%0d want 1 4095", change_valid, change);
    end
    tick();
  endtask

  task automatic test_out_of_stock();
    repeat (4) purchase(8'd25, 5'b00100);
    select = 5'b00100;
    tests++;
    if (stock !== 1'b0) begin
      fails++;
      $display("FAIL oos_empty got %b want 0", stock);
    end
    put_coin(8'd100);
    press_buy();
    tick();
    tests++;
    if (fault !== 2'd3 || moneyIn !== 12'd100 || dispense_valid !== 1'b0) begin
      fails++;
      $display("FAIL oos fault=%0d money=%0d dv=%b want 3 100 0",
               fault, moneyIn, dispense_valid);
    end
    press_restock();
    tests++;
    if (stock !== 1'b1) begin
      fails++;
      $display("FAIL oos_restock got %b want 1", stock);
    end
    press_cancel();
    tick();
  endtask

  task automatic test_reset_dispense();
    repeat (4) purchase(8'd25, 5'b00100);
    put_coin(8'd80);
    select = 5'b01000;
    press_buy();
    tick();
    tests++;
    if (dispense_valid !== 1'b1 || dispense_item !== 5'b01000) begin
      fails++;
      $display("FAIL rstd_disp dv=%b item=%b want 1 01000", dispense_valid, dispense_item);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (dispense_valid !== 1'b0 || moneyIn !== 12'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstd_drop dv=%b money=%0d busy=%b want 0 0 0",
               dispense_valid, moneyIn, busy);
    end
    tick();
    reset = 1'b1;
    select = 5'b00100;
    tick();
    tests++;
    if (stock !== 1'b1) begin
      fails++;
      $display("FAIL rstd_stock got %b want 1", stock);
    end
  endtask

  task automatic test_timeout();
    int n;
    put_coin(8'd10);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (change_valid === 1'b1) break;
    end
    tests++;
    if (n !== 16 || change !== 12'd10) begin
      fails++;
      $display("FAIL timeout cycles=%0d change=%0d want 16 10", n, change);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_no_select();
    test_change();
    test_insufficient();
    test_overflow();
    test_out_of_stock();
    test_reset_dispense();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
